// File: rtl/lisnoc16_usb_upstream_arbiter.sv
// Packet-atomic round-robin arbiter: N NoC16 flit sources share one output link.
// Zero-latency forwarding; flow control passes straight through; orphan flits in IDLE are dropped and flagged.
module lisnoc16_usb_upstream_arbiter #(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [18*N-1:0]   in_flit,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [17:0]       out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      grant,
  output logic              locked,
  output logic              err_orphan
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] FT_PAYLOAD = 2'b00;
  localparam logic [1:0] FT_HEADER  = 2'b01;
  localparam logic [1:0] FT_LAST    = 2'b10;
  localparam logic [1:0] FT_SINGLE  = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state;
  logic [PW-1:0]  own;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win;
  logic [PW-1:0]  orph;
  logic           win_vld;
  logic           orph_vld;
  logic [N-1:0]   cand;
  logic [N-1:0]   orphan;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(N-1)) ? '0 : i + PW'(1);
  endfunction

  always_comb begin
    cand   = '0;
    orphan = '0;
    for (int i = 0; i < N; i++) begin
      cand[i]   = in_valid[i] && (in_flit[18*i+16 +: 2] == FT_HEADER ||
                                  in_flit[18*i+16 +: 2] == FT_SINGLE);
      orphan[i] = in_valid[i] && (in_flit[18*i+16 +: 2] == FT_PAYLOAD ||
                                  in_flit[18*i+16 +: 2] == FT_LAST);
    end
  end

  // Winner: first candidate at or after ptr, wrapping; orphan: lowest index.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    orph     = '0;
    orph_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!win_vld && cand[j]) begin
        win     = PW'(j);
        win_vld = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (orphan[i]) begin
        orph     = PW'(i);
        orph_vld = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = '0;
    grant     = '0;
    out_flit  = '0;
    out_valid = 1'b0;
    if (state == LOCKED) begin
      out_flit      = in_flit[18*own +: 18];
      out_valid     = in_valid[own];
      in_ready[own] = out_ready;
      grant[own]    = 1'b1;
    end else if (win_vld) begin
      out_flit      = in_flit[18*win +: 18];
      out_valid     = 1'b1;
      in_ready[win] = out_ready;
      grant[win]    = 1'b1;
    end else if (orph_vld) begin
      // Orphan is swallowed without touching the output link.
      in_ready[orph] = 1'b1;
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      own        <= '0;
      ptr        <= '0;
      err_orphan <= 1'b0;
    end else begin
      err_orphan <= (state == IDLE) && !win_vld && orph_vld;
      case (state)
        IDLE: begin
          if (win_vld && out_ready) begin
            if (out_flit[17:16] == FT_HEADER) begin
              state <= LOCKED;
              own   <= win;
            end else begin
              ptr <= next_idx(win);
            end
          end
        end
        LOCKED: begin
          if (out_valid && out_ready && out_flit[17:16] == FT_LAST) begin
            state <= IDLE;
            ptr   <= next_idx(own);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lisnoc16_usb_upstream_arbiter.sv
// Directed bench for lisnoc16_usb_upstream_arbiter with N=4 requesters.
module tb_lisnoc16_usb_upstream_arbiter;

  localparam int N = 4;
  localparam logic [1:0] PAY = 2'b00;
  localparam logic [1:0] HDR = 2'b01;
  localparam logic [1:0] LST = 2'b10;
  localparam logic [1:0] SGL = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [18*N-1:0] in_flit;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [17:0]     out_flit;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            locked;
  logic            err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  lisnoc16_usb_upstream_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant      (grant),
    .locked     (locked),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int i, input logic [1:0] t, input logic [15:0] d, input logic v);
    in_flit[18*i +: 18] = {t, d};
    in_valid[i]         = v;
  endtask

  task automatic idle_all();
    in_flit  = '0;
    in_valid = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle_all();
    @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_orphan), 32'd0);
    rst = 1'b0;
    tick();

    // Round robin of SINGLEs from req0/req1
    drv(0, SGL, 16'hAAAA, 1'b1);
    drv(1, SGL, 16'hBBBB, 1'b1);
    #2;
    chk("rr0_flit", 32'(out_flit), 32'h3AAAA);
    chk("rr0_ready", 32'(in_ready), 32'h1);
    tick(); #2;
    chk("rr1_flit", 32'(out_flit), 32'h3BBBB);
    chk("rr1_ready", 32'(in_ready), 32'h2);
    tick(); #2;
    chk("rr2_flit", 32'(out_flit), 32'h3AAAA);
    tick(); #2;
    chk("rr3_flit", 32'(out_flit), 32'h3BBBB);
    chk("rr3_grant", 32'(grant), 32'h2);
    tick();
    idle_all();

    // Packet atomicity: ptr=2, req0 header wins
    drv(0, HDR, 16'h0100, 1'b1);
    #2;
    chk("pk_hdr_flit", 32'(out_flit), 32'h10100);
    chk("pk_hdr_locked", 32'(locked), 32'd0);
    tick();
    drv(0, PAY, 16'h0101, 1'b1);
    drv(1, SGL, 16'h0200, 1'b1);
    #2;
    chk("pk_pay_flit", 32'(out_flit), 32'h00101);
    chk("pk_pay_locked", 32'(locked), 32'd1);
    chk("pk_pay_ready", 32'(in_ready), 32'h1);
    tick();
    drv(0, LST, 16'h0102, 1'b1);
    #2;
    chk("pk_lst_flit", 32'(out_flit), 32'h20102);
    chk("pk_lst_ready", 32'(in_ready), 32'h1);
    tick();
    drv(0, PAY, 16'h0000, 1'b0);
    #2;
    chk("pk_sgl_flit", 32'(out_flit), 32'h30200);
    chk("pk_sgl_ready", 32'(in_ready), 32'h2);
    chk("pk_sgl_locked", 32'(locked), 32'd0);
    tick();
    idle_all();

    // Backpressure mid-packet on req1 (ptr=2 -> search 2,3,0,1)
    drv(1, HDR, 16'h0300, 1'b1);
    #2;
    chk("bp_hdr_grant", 32'(grant), 32'h2);
    tick();
    drv(1, PAY, 16'h0301, 1'b1);
    drv(0, SGL, 16'h0400, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("bp_stall_flit", 32'(out_flit), 32'h00301);
      chk("bp_stall_ready", 32'(in_ready), 32'h0);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #2;
    chk("bp_rel_flit", 32'(out_flit), 32'h00301);
    chk("bp_rel_ready", 32'(in_ready), 32'h2);
    tick();
    drv(1, LST, 16'h0302, 1'b1);
    #2;
    chk("bp_lst_flit", 32'(out_flit), 32'h20302);
    tick();
    drv(1, PAY, 16'h0000, 1'b0);
    #2;
    chk("bp_next_flit", 32'(out_flit), 32'h30400);
    chk("bp_next_grant", 32'(grant), 32'h1);
    tick();
    idle_all();

    // Orphan drop (ptr=1)
    drv(1, LST, 16'h1234, 1'b1);
    #2;
    chk("or_ready", 32'(in_ready), 32'h2);
    chk("or_valid", 32'(out_valid), 32'd0);
    chk("or_flit", 32'(out_flit), 32'h0);
    chk("or_err_now", 32'(err_orphan), 32'd0);
    tick();
    idle_all();
    #2;
    chk("or_err_pulse", 32'(err_orphan), 32'd1);
    tick(); #2;
    chk("or_err_clear", 32'(err_orphan), 32'd0);

    // Orphan waits while a candidate exists
    drv(1, PAY, 16'h5555, 1'b1);
    drv(3, SGL, 16'h6666, 1'b1);
    #2;
    chk("orw_ready", 32'(in_ready), 32'h8);
    chk("orw_flit", 32'(out_flit), 32'h36666);
    tick();
    idle_all();
    #2;
    chk("orw_err", 32'(err_orphan), 32'd0);
    tick();

    // Async reset mid-packet (ptr=0 -> req1 header)
    drv(1, HDR, 16'h0500, 1'b1);
    #2;
    chk("ar_hdr_grant", 32'(grant), 32'h2);
    tick();
    drv(1, PAY, 16'h0501, 1'b1);
    out_ready = 1'b0;
    #2;
    chk("ar_locked_before", 32'(locked), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_locked", 32'(locked), 32'd0);
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_orph_ready", 32'(in_ready), 32'h2);
    #1;
    rst = 1'b0;
    tick();
    idle_all();
    out_ready = 1'b1;
    #2;
    chk("ar_err", 32'(err_orphan), 32'd1);
    tick();

    // Wrap-around: push ptr to 3 with a SINGLE from req2
    drv(2, SGL, 16'h0777, 1'b1);
    #2;
    chk("wr_sgl_grant", 32'(grant), 32'h4);
    tick();
    drv(0, HDR, 16'h0600, 1'b1);
    drv(2, HDR, 16'h0700, 1'b1);
    #2;
    chk("wr_first_grant", 32'(grant), 32'h1);
    chk("wr_first_flit", 32'(out_flit), 32'h10600);
    tick();
    drv(0, LST, 16'h0601, 1'b1);
    #2;
    chk("wr_lst_flit", 32'(out_flit), 32'h20601);
    chk("wr_lst_ready", 32'(in_ready), 32'h1);
    tick();
    drv(0, PAY, 16'h0000, 1'b0);
    #2;
    chk("wr_second_grant", 32'(grant), 32'h4);
    chk("wr_second_flit", 32'(out_flit), 32'h10700);
    tick();
    drv(2, LST, 16'h0701, 1'b1);
    #2;
    chk("wr_second_locked", 32'(locked), 32'd1);
    tick();
    idle_all();
    #2;
    chk("wr_end_locked", 32'(locked), 32'd0);
    chk("wr_end_grant", 32'(grant), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
